hazard_ctrl: RTL

//  ID-stage hazard/stall controller for the 5-stage MIPS pipeline. Detects load-use and branch-operand

---
 rtl/pipe_pkg.sv | 31 +++
 rtl/hazard_perf_cnt.sv | 33 +++
 rtl/hazard_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared pipeline constants for the 5-stage MIPS core: branch
//               opcodes, MEM write-back source encodings, hazard FSM states
//               and a register-match helper used by the hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;

   localparam logic [1:0] SDW_ALU = 2'b00;
   localparam logic [1:0] SDW_MEM = 2'b01;

   typedef enum logic [0:0] {
      HZ_RUN    = 1'b0,
      HZ_STALL1 = 1'b1
   } hz_state_t;

   // A source register depends on a producer only if the producer writes,
   // the source is not r0, and the register numbers agree.
   function automatic logic reg_match(input logic [4:0] src,
                                      input logic [4:0] dst,
                                      input logic       we);
      return we && (src != 5'd0) && (src == dst);
   endfunction

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/hazard_perf_cnt.sv
`default_nettype none
// ============================================================================
// Module      : hazard_perf_cnt
// Description : Saturating event counter. Increments once per cycle while
//               inc is high, holds at all-ones, synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_perf_cnt #(
   parameter int PERF_W = 32
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              inc,
   input  logic              clear,
   output logic [PERF_W-1:0] count
);

   localparam logic [PERF_W-1:0] CNT_ONE = {{(PERF_W-1){1'b0}}, 1'b1};
   localparam logic [PERF_W-1:0] CNT_MAX = {PERF_W{1'b1}};

   // Count events, stop at all-ones so the value never wraps back to zero.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc && (count != CNT_MAX)) begin
         count <= count + CNT_ONE;
      end
   end

endmodule : hazard_perf_cnt
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : ID-stage hazard/stall controller. Stalls PC and IF/ID and
//               bubbles ID/EX for load-use and branch-operand hazards that
//               the forwarding unit cannot cover; flushes IF/ID on a taken
//               branch once no stall is pending.
//               Optional feature macro: HAZARD_PERF_EN enables saturating
//               stall/flush event counters (ports tied to zero otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int PERF_W = 32
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic [5:0]        op,
   input  logic [4:0]        rs,
   input  logic [4:0]        rt,
   input  logic [4:0]        EXE_num_write,
   input  logic              EXE_reg_write,
   input  logic              EXE_mem_read,
   input  logic [4:0]        MEM_num_write,
   input  logic              MEM_reg_write,
   input  logic [1:0]        MEM_s_data_write,
   input  logic              branch_taken,
   output logic              pc_write,
   output logic              IFID_write,
   output logic              IDEX_bubble,
   output logic              IFID_flush,
   output logic [PERF_W-1:0] stall_cnt,
   output logic [PERF_W-1:0] flush_cnt
);

   hz_state_t   state_q;
   hz_state_t   state_d;
   logic        is_branch;
   logic        ex_hit;
   logic        mem_hit;
   logic [1:0]  depth;
   logic        stall;

   assign is_branch = (op == OP_BEQ) || (op == OP_BNE);
   assign ex_hit    = reg_match(rs, EXE_num_write, EXE_reg_write) |
                      reg_match(rt, EXE_num_write, EXE_reg_write);
   assign mem_hit   = reg_match(rs, MEM_num_write, MEM_reg_write) |
                      reg_match(rt, MEM_num_write, MEM_reg_write);

   // Hazard depth: how many bubbles the ID instruction needs. A branch reading
   // a load in EX needs the data two cycles later; a branch behind a MEM-stage
   // ALU result is served by forwarding and needs none.
   always_comb begin
      depth = 2'd0;
      if (is_branch && EXE_mem_read && ex_hit) begin
         depth = 2'd2;
      end else if (is_branch && !EXE_mem_read && ex_hit) begin
         depth = 2'd1;
      end else if (is_branch && (MEM_s_data_write == SDW_MEM) && mem_hit) begin
         depth = 2'd1;
      end else if (!is_branch && EXE_mem_read && ex_hit) begin
         depth = 2'd1;
      end
   end

   // Next state and Mealy stall decision; reset forces the free-running outputs.
   always_comb begin
      state_d = state_q;
      stall   = 1'b0;
      if (!resetn) begin
         state_d = HZ_RUN;
         stall   = 1'b0;
      end else begin
         case (state_q)
            HZ_RUN: begin
               stall = (depth != 2'd0);
               if (depth == 2'd2) begin
                  state_d = HZ_STALL1;
               end
            end
            HZ_STALL1: begin
               stall   = 1'b1;
               state_d = HZ_RUN;
            end
            default: begin
               stall   = 1'b0;
               state_d = HZ_RUN;
            end
         endcase
      end
   end

   // The branch outcome is not trustworthy while stalling, so a flush only
   // goes out in a cycle with no stall.
   always_comb begin
      pc_write    = !stall;
      IFID_write  = !stall;
      IDEX_bubble = stall;
      IFID_flush  = resetn && branch_taken && !stall;
   end

   // FSM state register.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= HZ_RUN;
      end else begin
         state_q <= state_d;
      end
   end

`ifdef HAZARD_PERF_EN
   hazard_perf_cnt #(
      .PERF_W (PERF_W)
   ) u_stall_cnt (
      .clock  (clock),
      .resetn (resetn),
      .inc    (IDEX_bubble),
      .clear  (1'b0),
      .count  (stall_cnt)
   );

   hazard_perf_cnt #(
      .PERF_W (PERF_W)
   ) u_flush_cnt (
      .clock  (clock),
      .resetn (resetn),
      .inc    (IFID_flush),
      .clear  (1'b0),
      .count  (flush_cnt)
   );
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule : hazard_ctrl
`default_nettype wire
